// File: rtl/cva6_spi_master_pkg.sv
// Shared definitions for the SPI master transfer controller.
// Holds the state encoding, status bit positions and spi_mode encodings.
// Pure declarations; no logic.
package cva6_spi_master_pkg;

  // Enum values double as the one-hot status bit index of each state.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DUMMY   = 3'd3,
    ST_DATA_TX = 3'd4,
    ST_DATA_RX = 3'd5,
    ST_DONE    = 3'd6
  } spi_state_e;

  localparam int unsigned STAT_IDLE    = 0;
  localparam int unsigned STAT_CMD     = 1;
  localparam int unsigned STAT_ADDR    = 2;
  localparam int unsigned STAT_DUMMY   = 3;
  localparam int unsigned STAT_DATA_TX = 4;
  localparam int unsigned STAT_DATA_RX = 5;
  localparam int unsigned STAT_DONE    = 6;

  localparam logic [1:0] MODE_STD     = 2'b00;
  localparam logic [1:0] MODE_QUAD_TX = 2'b01;
  localparam logic [1:0] MODE_QUAD_RX = 2'b10;

  // One-hot status word for a state; upper bits always zero.
  function automatic logic [31:0] status_word(input spi_state_e s);
    logic [31:0] w;
    w = '0;
    case (s)
      ST_IDLE:    w[STAT_IDLE]    = 1'b1;
      ST_CMD:     w[STAT_CMD]     = 1'b1;
      ST_ADDR:    w[STAT_ADDR]    = 1'b1;
      ST_DUMMY:   w[STAT_DUMMY]   = 1'b1;
      ST_DATA_TX: w[STAT_DATA_TX] = 1'b1;
      ST_DATA_RX: w[STAT_DATA_RX] = 1'b1;
      ST_DONE:    w[STAT_DONE]    = 1'b1;
      default:    w[STAT_IDLE]    = 1'b1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cva6_spi_master_controller.sv
// SPI master transfer sequencer: CMD -> ADDR -> DUMMY -> DATA -> DONE, skipping empty phases.
// Latency: start strobe reaches the first non-empty phase on the next cycle; phases end one cycle after done/count-zero.
// Backpressure: none; phases wait on tx_done/rx_done/spi_clk_edge, spi_swrst aborts from any state.
module cva6_spi_master_controller
  import cva6_spi_master_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        spi_rd,
  input  logic        spi_wr,
  input  logic        spi_qrd,
  input  logic        spi_qwr,
  input  logic        spi_swrst,
  input  logic [3:0]  spi_csreg,
  input  logic [5:0]  spi_cmd_len,
  input  logic [5:0]  spi_addr_len,
  input  logic [15:0] spi_data_len,
  input  logic [15:0] spi_dummy_rd,
  input  logic [15:0] spi_dummy_wr,
  input  logic [31:0] spi_cmd,
  input  logic [31:0] spi_addr,
  output logic [31:0] spi_status,
  output logic        spi_clk_en,
  input  logic        spi_clk_edge,
  output logic [3:0]  spi_csn,
  output logic [1:0]  spi_mode,
  output logic        tx_start,
  output logic [15:0] tx_len,
  output logic [31:0] tx_data,
  output logic        tx_src_fifo,
  input  logic        tx_done,
  output logic        rx_start,
  output logic [15:0] rx_len,
  input  logic        rx_done,
  output logic        eot
);

  spi_state_e  state, state_next;
  spi_state_e  after_dummy, after_addr, after_cmd, first_phase, data_state;
  logic        is_read_q, is_quad_q;
  logic [3:0]  csreg_q;
  logic [15:0] dummy_cnt;
  logic        start_any, start_read, start_quad, path_read, active;
  logic [15:0] dummy_len;

  assign start_any = spi_rd | spi_wr | spi_qrd | spi_qwr;

  // Fixed-priority decode of simultaneous start strobes: rd > wr > qrd > qwr.
  always_comb begin
    start_read = 1'b0;
    start_quad = 1'b0;
    if (spi_rd) begin
      start_read = 1'b1;
    end else if (spi_wr) begin
      start_read = 1'b0;
    end else if (spi_qrd) begin
      start_read = 1'b1;
      start_quad = 1'b1;
    end else if (spi_qwr) begin
      start_quad = 1'b1;
    end
  end

  // In IDLE the transfer type is not latched yet, so use the strobe decode directly.
  assign path_read  = (state == ST_IDLE) ? start_read : is_read_q;
  assign dummy_len  = path_read ? spi_dummy_rd : spi_dummy_wr;
  assign data_state = path_read ? ST_DATA_RX : ST_DATA_TX;

  // Skip chain: each phase's successor falls through every zero-length phase.
  assign after_dummy = (spi_data_len != 16'd0) ? data_state : ST_DONE;
  assign after_addr  = (dummy_len != 16'd0)    ? ST_DUMMY   : after_dummy;
  assign after_cmd   = (spi_addr_len != 6'd0)  ? ST_ADDR    : after_addr;
  assign first_phase = (spi_cmd_len != 6'd0)   ? ST_CMD     : after_cmd;

  // Next-state selection; soft reset overrides starts and done pulses.
  always_comb begin
    state_next = state;
    if (spi_swrst) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start_any) state_next = first_phase;
        ST_CMD:     if (tx_done) state_next = after_cmd;
        ST_ADDR:    if (tx_done) state_next = after_addr;
        ST_DUMMY:   if (dummy_cnt == 16'd0) state_next = after_dummy;
        ST_DATA_TX: if (tx_done) state_next = ST_DONE;
        ST_DATA_RX: if (rx_done) state_next = ST_DONE;
        ST_DONE:    state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Capture transfer type and chip-select mask when a start is accepted.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      is_read_q <= 1'b0;
      is_quad_q <= 1'b0;
      csreg_q   <= 4'h0;
    end else if ((state == ST_IDLE) && start_any && !spi_swrst) begin
      is_read_q <= start_read;
      is_quad_q <= start_quad;
      csreg_q   <= spi_csreg;
    end
  end

  // Dummy down-counter: load on DUMMY entry, count SCK edges while in DUMMY.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dummy_cnt <= 16'd0;
    end else if (spi_swrst) begin
      dummy_cnt <= 16'd0;
    end else if ((state_next == ST_DUMMY) && (state != ST_DUMMY)) begin
      dummy_cnt <= dummy_len;
    end else if ((state == ST_DUMMY) && spi_clk_edge && (dummy_cnt != 16'd0)) begin
      dummy_cnt <= dummy_cnt - 16'd1;
    end
  end

  // Registered start pulses, high in the first cycle of each shifting phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_start <= 1'b0;
      rx_start <= 1'b0;
    end else begin
      tx_start <= (state_next != state) &&
                  ((state_next == ST_CMD) || (state_next == ST_ADDR) || (state_next == ST_DATA_TX));
      rx_start <= (state_next != state) && (state_next == ST_DATA_RX);
    end
  end

  assign active = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DUMMY) ||
                  (state == ST_DATA_TX) || (state == ST_DATA_RX);

  // Shifter setup decoded from the current phase.
  always_comb begin
    tx_data     = 32'd0;
    tx_len      = 16'd0;
    tx_src_fifo = 1'b0;
    rx_len      = 16'd0;
    case (state)
      ST_CMD: begin
        tx_data = spi_cmd;
        tx_len  = {10'd0, spi_cmd_len};
      end
      ST_ADDR: begin
        tx_data = spi_addr;
        tx_len  = {10'd0, spi_addr_len};
      end
      ST_DATA_TX: begin
        tx_len      = spi_data_len;
        tx_src_fifo = 1'b1;
      end
      ST_DATA_RX: rx_len = spi_data_len;
      default: ;
    endcase
  end

  assign spi_clk_en = active;
  assign spi_csn    = active ? ~csreg_q : 4'hF;
  assign spi_mode   = (active && is_quad_q) ? (is_read_q ? MODE_QUAD_RX : MODE_QUAD_TX) : MODE_STD;
  // An abort arriving in DONE suppresses the end-of-transfer pulse.
  assign eot        = (state == ST_DONE) && !spi_swrst;
  assign spi_status = status_word(state);

endmodule

// File: tb/tb_cva6_spi_master_controller.sv
module tb_cva6_spi_master_controller;

  logic        HCLK, HRESETn;
  logic        spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst;
  logic [3:0]  spi_csreg;
  logic [5:0]  spi_cmd_len, spi_addr_len;
  logic [15:0] spi_data_len, spi_dummy_rd, spi_dummy_wr;
  logic [31:0] spi_cmd, spi_addr;
  logic [31:0] spi_status;
  logic        spi_clk_en, spi_clk_edge;
  logic [3:0]  spi_csn;
  logic [1:0]  spi_mode;
  logic        tx_start, tx_src_fifo, tx_done;
  logic [15:0] tx_len, rx_len;
  logic [31:0] tx_data;
  logic        rx_start, rx_done, eot;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] S_IDLE  = 32'h01;
  localparam logic [31:0] S_CMD   = 32'h02;
  localparam logic [31:0] S_ADDR  = 32'h04;
  localparam logic [31:0] S_DUMMY = 32'h08;
  localparam logic [31:0] S_TX    = 32'h10;
  localparam logic [31:0] S_RX    = 32'h20;
  localparam logic [31:0] S_DONE  = 32'h40;

  cva6_spi_master_controller dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_qrd(spi_qrd), .spi_qwr(spi_qwr), .spi_swrst(spi_swrst),
    .spi_csreg(spi_csreg), .spi_cmd_len(spi_cmd_len), .spi_addr_len(spi_addr_len),
    .spi_data_len(spi_data_len), .spi_dummy_rd(spi_dummy_rd), .spi_dummy_wr(spi_dummy_wr),
    .spi_cmd(spi_cmd), .spi_addr(spi_addr), .spi_status(spi_status),
    .spi_clk_en(spi_clk_en), .spi_clk_edge(spi_clk_edge), .spi_csn(spi_csn), .spi_mode(spi_mode),
    .tx_start(tx_start), .tx_len(tx_len), .tx_data(tx_data), .tx_src_fifo(tx_src_fifo), .tx_done(tx_done),
    .rx_start(rx_start), .rx_len(rx_len), .rx_done(rx_done), .eot(eot)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic clk_edge_pulse();
    spi_clk_edge = 1'b1;
    tick();
    spi_clk_edge = 1'b0;
  endtask

  task automatic tx_done_pulse();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic rx_done_pulse();
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  initial begin
    HRESETn = 1'b0;
    spi_rd = 0; spi_wr = 0; spi_qrd = 0; spi_qwr = 0; spi_swrst = 0;
    spi_clk_edge = 0; tx_done = 0; rx_done = 0;
    spi_csreg = 4'b0001; spi_cmd_len = 6'd8; spi_addr_len = 6'd24;
    spi_data_len = 16'd32; spi_dummy_rd = 16'd8; spi_dummy_wr = 16'd0;
    spi_cmd = 32'h0000_00EB; spi_addr = 32'h0012_3456;

    // Reset state
    tick(); tick();
    check("rst_status", spi_status, 32'h1);
    check("rst_csn", spi_csn, 4'hF);
    check("rst_clk_en", spi_clk_en, 1'b0);
    check("rst_eot", eot, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_mode", spi_mode, 2'b00);
    HRESETn = 1'b1;
    tick();

    // Standard read: CMD 8, ADDR 24, DUMMY 8, DATA_RX 32
    spi_rd = 1'b1; tick(); spi_rd = 1'b0;
    spi_csreg = 4'hF;  // must not disturb the latched mask
    check("rd_cmd_state", spi_status, S_CMD);
    check("rd_cmd_txstart", tx_start, 1'b1);
    check("rd_cmd_txlen", tx_len, 16'd8);
    check("rd_cmd_txdata", tx_data, 32'h0000_00EB);
    check("rd_cmd_fifo", tx_src_fifo, 1'b0);
    check("rd_cmd_csn", spi_csn, 4'b1110);
    check("rd_cmd_clken", spi_clk_en, 1'b1);
    check("rd_cmd_mode", spi_mode, 2'b00);
    tick();
    check("rd_cmd_txstart_1cyc", tx_start, 1'b0);
    check("rd_cmd_hold", spi_status, S_CMD);
    tx_done_pulse();
    check("rd_addr_state", spi_status, S_ADDR);
    check("rd_addr_txstart", tx_start, 1'b1);
    check("rd_addr_txlen", tx_len, 16'd24);
    check("rd_addr_txdata", tx_data, 32'h0012_3456);
    tx_done_pulse();
    check("rd_dummy_state", spi_status, S_DUMMY);
    check("rd_dummy_csn", spi_csn, 4'b1110);
    check("rd_dummy_txstart", tx_start, 1'b0);
    for (int i = 0; i < 7; i++) clk_edge_pulse();
    check("rd_dummy_7edges", spi_status, S_DUMMY);
    clk_edge_pulse();
    check("rd_dummy_8edges", spi_status, S_DUMMY);
    tick();
    check("rd_rx_state", spi_status, S_RX);
    check("rd_rx_start", rx_start, 1'b1);
    check("rd_rx_len", rx_len, 16'd32);
    check("rd_rx_csn", spi_csn, 4'b1110);
    spi_wr = 1'b1; tick(); spi_wr = 1'b0;
    check("rd_wr_ignored", spi_status, S_RX);
    check("rd_rx_start_1cyc", rx_start, 1'b0);
    rx_done_pulse();
    check("rd_done_state", spi_status, S_DONE);
    check("rd_done_eot", eot, 1'b1);
    check("rd_done_csn", spi_csn, 4'hF);
    check("rd_done_clken", spi_clk_en, 1'b0);
    tick();
    check("rd_idle", spi_status, S_IDLE);
    check("rd_idle_eot", eot, 1'b0);

    // Quad write: CMD 8, ADDR 0, DUMMY 0, DATA_TX 64
    spi_csreg = 4'b0100; spi_addr_len = 6'd0; spi_dummy_wr = 16'd0;
    spi_dummy_rd = 16'd9; spi_data_len = 16'd64;
    spi_qwr = 1'b1; tick(); spi_qwr = 1'b0;
    check("qw_cmd_state", spi_status, S_CMD);
    check("qw_cmd_mode", spi_mode, 2'b01);
    check("qw_cmd_csn", spi_csn, 4'b1011);
    tx_done_pulse();
    check("qw_tx_state", spi_status, S_TX);
    check("qw_tx_start", tx_start, 1'b1);
    check("qw_tx_len", tx_len, 16'd64);
    check("qw_tx_fifo", tx_src_fifo, 1'b1);
    check("qw_tx_mode", spi_mode, 2'b01);
    tx_done_pulse();
    check("qw_done_eot", eot, 1'b1);
    check("qw_done_mode", spi_mode, 2'b00);
    tick();
    check("qw_idle", spi_status, S_IDLE);

    // All-zero-length write
    spi_cmd_len = 6'd0; spi_data_len = 16'd0; spi_dummy_rd = 16'd5;
    spi_wr = 1'b1; tick(); spi_wr = 1'b0;
    check("zw_done", spi_status, S_DONE);
    check("zw_eot", eot, 1'b1);
    check("zw_clken", spi_clk_en, 1'b0);
    tick();
    check("zw_idle", spi_status, S_IDLE);

    // Simultaneous rd+wr: read path (dummy_wr would route to DUMMY)
    spi_csreg = 4'b0001; spi_dummy_rd = 16'd0; spi_dummy_wr = 16'd3; spi_data_len = 16'd16;
    spi_rd = 1'b1; spi_wr = 1'b1; tick(); spi_rd = 1'b0; spi_wr = 1'b0;
    check("sim_rx_state", spi_status, S_RX);
    check("sim_rx_start", rx_start, 1'b1);
    check("sim_rx_len", rx_len, 16'd16);
    rx_done_pulse();
    check("sim_eot", eot, 1'b1);
    tick();

    // Abort in DUMMY with 3 edges left
    spi_dummy_rd = 16'd5; spi_data_len = 16'd8;
    spi_rd = 1'b1; tick(); spi_rd = 1'b0;
    check("ab_dummy", spi_status, S_DUMMY);
    clk_edge_pulse(); clk_edge_pulse();
    spi_swrst = 1'b1; tick(); spi_swrst = 1'b0;
    check("ab_idle", spi_status, S_IDLE);
    check("ab_csn", spi_csn, 4'hF);
    check("ab_clken", spi_clk_en, 1'b0);
    check("ab_eot", eot, 1'b0);
    spi_swrst = 1'b1; spi_rd = 1'b1; tick(); spi_swrst = 1'b0; spi_rd = 1'b0;
    check("ab_swrst_beats_start", spi_status, S_IDLE);
    spi_rd = 1'b1; tick(); spi_rd = 1'b0;
    check("ab_restart_dummy", spi_status, S_DUMMY);
    for (int i = 0; i < 4; i++) clk_edge_pulse();
    check("ab_restart_4edges", spi_status, S_DUMMY);
    clk_edge_pulse();
    tick();
    check("ab_restart_rx", spi_status, S_RX);
    rx_done_pulse();
    check("ab_restart_eot", eot, 1'b1);
    tick();

    // Asynchronous reset during DATA_TX
    spi_dummy_wr = 16'd0; spi_data_len = 16'd16;
    spi_wr = 1'b1; tick(); spi_wr = 1'b0;
    check("rs_tx_state", spi_status, S_TX);
    check("rs_tx_clken", spi_clk_en, 1'b1);
    #2 HRESETn = 1'b0;
    #1;
    check("rs_status", spi_status, 32'h1);
    check("rs_csn", spi_csn, 4'hF);
    check("rs_clken", spi_clk_en, 1'b0);
    check("rs_eot", eot, 1'b0);
    tick();
    HRESETn = 1'b1;
    tick();
    check("rs_after_idle", spi_status, S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
